flappy_vga_render: RTL and testbench

- Downstream consumer of the game-logic stage: takes ball_y, pillar_x, pillar_y, score and draws them on a 640x480@60 Hz VGA raster.
- Generates HS/VS/blank timing from the 50 MHz board clock using an internal divide-by-2 pixel enable.
- Emits a one-cycle frame_tick at the start of vertical blank. The top level uses it to advance the game logic once per frame.
- Latches the game state into shadow registers on that tick so each frame is drawn tear-free.

---
 rtl/flappy_vga_render.sv | 172 +++++++++++++++++
 tb/tb_flappy_vga_render.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_vga_render.sv
// Purpose : 640x480@60 VGA raster, sync generation and sprite colouring for the flappy game state.
// Latency : one pixel (two clk) from raster counters to hsync/vsync/blank_n/rgb, all aligned.
// Backpr. : none; free-running raster, inputs are sampled only on frame_tick.
//
// Ports:
//   clk, reset            50 MHz clock, async active-low reset
//   ball_y, pillar_x,     game state from the logic stage, captured into shadow
//   pillar_y, score       registers once per frame (on frame_tick)
//   hsync, vsync          active-low syncs
//   blank_n               high in the visible area
//   vga_r/g/b             8-bit colour, zero while blanked
//   frame_tick            one-clk pulse at the start of vertical blank
//
// Build option: define FLAPPY_SCORE_BAR_EN to draw the score bar (rows 0..7).
// Without it the score input is unused and those pixels show background.
module flappy_vga_render #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int BALL_X        = 213,
    parameter int BALL_WIDTH    = 10,
    parameter int BALL_HEIGHT   = 10,
    parameter int PILLAR_WIDTH  = 50,
    parameter int PILLAR_HEIGHT = 80,
    parameter int SCORE_BLK     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ball_y,
    input  logic [9:0] pillar_x,
    input  logic [9:0] pillar_y,
    input  logic [7:0] score,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [23:0] C_BALL   = 24'hFFFF00;
    localparam logic [23:0] C_PILLAR = 24'h00C000;
    localparam logic [23:0] C_SCORE  = 24'hFFFFFF;
    localparam logic [23:0] C_BG     = 24'h40A0FF;

    logic        pen_q;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hsync_q, vsync_q, blank_n_q;
    logic [23:0] rgb_q, rgb_d;
    logic [9:0]  sb_y_q, sp_x_q, sp_y_q;
    logic        tick;

    // Raster advance: counters only move on the pixel-enable phase.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pen_q) begin
            if (hcount_q == 10'(H_TOTAL - 1)) begin
                hcount_d = 10'd0;
                vcount_d = (vcount_q == 10'(V_TOTAL - 1)) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Combinational so it lands on the very edge that also loads the shadows.
    assign tick = pen_q && (hcount_q == 10'd0) && (vcount_q == 10'(V_ACTIVE));

    // Everything below is evaluated in 11 bits so position + size never wraps.
    logic [10:0] px, py, sb_y, sp_x, sp_y;
    logic        visible, hs_n, vs_n;
    logic        in_ball, in_pillar, in_score;

    assign px   = {1'b0, hcount_q};
    assign py   = {1'b0, vcount_q};
    assign sb_y = {1'b0, sb_y_q};
    assign sp_x = {1'b0, sp_x_q};
    assign sp_y = {1'b0, sp_y_q};

    assign visible = (px < 11'(H_ACTIVE)) && (py < 11'(V_ACTIVE));
    assign hs_n    = !((px >= 11'(H_ACTIVE + H_FP)) && (px < 11'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_n    = !((py >= 11'(V_ACTIVE + V_FP)) && (py < 11'(V_ACTIVE + V_FP + V_SYNC)));

    assign in_ball = (px >= 11'(BALL_X)) && (px < 11'(BALL_X + BALL_WIDTH)) &&
                     (py >= sb_y) && (py < sb_y + 11'(BALL_HEIGHT));

    // Pillar is drawn above the gap and below it; sp_y == 0 leaves no upper part.
    assign in_pillar = (px >= sp_x) && (px < sp_x + 11'(PILLAR_WIDTH)) &&
                       ((py < sp_y) || (py >= sp_y + 11'(PILLAR_HEIGHT)));

`ifdef FLAPPY_SCORE_BAR_EN
    logic [7:0]  s_score_q;
    logic [10:0] score_blocks, bar_w;

    // Bar saturates at 40 blocks, which is exactly the visible width.
    assign score_blocks = (s_score_q > 8'd40) ? 11'd40 : {3'b000, s_score_q};
    assign bar_w        = score_blocks * 11'(SCORE_BLK);
    // Last two columns of each block are left as background to separate blocks.
    assign in_score     = (py < 11'd8) && (px < bar_w) &&
                          ((px % 11'(SCORE_BLK)) < 11'(SCORE_BLK - 2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    s_score_q <= 8'd0;
        else if (tick) s_score_q <= score;
    end
`else
    logic score_unused;
    assign score_unused = ^score;
    assign in_score     = 1'b0;
`endif

    always_comb begin
        rgb_d = 24'h000000;
        if (visible) begin
            if (in_ball)        rgb_d = C_BALL;
            else if (in_pillar) rgb_d = C_PILLAR;
            else if (in_score)  rgb_d = C_SCORE;
            else                rgb_d = C_BG;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pen_q     <= 1'b0;
            hcount_q  <= 10'd0;
            vcount_q  <= 10'd0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= 24'h000000;
            sb_y_q    <= 10'd240;
            sp_x_q    <= 10'd640;
            sp_y_q    <= 10'd0;
        end else begin
            pen_q    <= ~pen_q;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            // Sync and colour share one register stage to stay pixel-aligned.
            if (pen_q) begin
                hsync_q   <= hs_n;
                vsync_q   <= vs_n;
                blank_n_q <= visible;
                rgb_q     <= rgb_d;
            end
            if (tick) begin
                sb_y_q <= ball_y;
                sp_x_q <= pillar_x;
                sp_y_q <= pillar_y;
            end
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign blank_n    = blank_n_q;
    assign vga_r      = rgb_q[23:16];
    assign vga_g      = rgb_q[15:8];
    assign vga_b      = rgb_q[7:0];
    assign frame_tick = tick;

endmodule

// File: tb/tb_flappy_vga_render.sv
`timescale 1ns/1ps
module tb_flappy_vga_render;

    // Full horizontal timing, vertical timing shortened to keep frames short.
    localparam int HT = 800;
    localparam int VA = 12;
    localparam int VT = 16;           // 12 + 1 + 2 + 1
    localparam int FR = HT * VT;      // pixels per frame

    localparam logic [23:0] C_BALL = 24'hFFFF00;
    localparam logic [23:0] C_PIL  = 24'h00C000;
    localparam logic [23:0] C_BG   = 24'h40A0FF;
    localparam logic [23:0] C_BLK  = 24'h000000;
`ifdef FLAPPY_SCORE_BAR_EN
    localparam logic [23:0] C_SC   = 24'hFFFFFF;
`else
    localparam logic [23:0] C_SC   = C_BG;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] ball_y, pillar_x, pillar_y;
    logic [7:0] score;
    logic       hsync, vsync, blank_n, frame_tick;
    logic [7:0] vga_r, vga_g, vga_b;

    flappy_vga_render #(
        .V_ACTIVE(VA), .V_FP(1), .V_SYNC(2), .V_BP(1), .PILLAR_HEIGHT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .ball_y(ball_y), .pillar_x(pillar_x), .pillar_y(pillar_y), .score(score),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_tick(frame_tick)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timing monitor, relative to the reset release cycle c0.
    int unsigned c0;
    bit   mon_en = 1'b0;
    int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], tk[$];
    int   tk_wide = 0;
    int   tick_total = 0;
    logic hs_p = 1'b1, vs_p = 1'b1, tk_p = 1'b0;

    always @(negedge clk) begin
        if (frame_tick) tick_total++;
        if (mon_en) begin
            if (hs_p && !hsync) hs_fall.push_back(int'(cyc - c0));
            if (!hs_p && hsync) hs_rise.push_back(int'(cyc - c0));
            if (vs_p && !vsync) vs_fall.push_back(int'(cyc - c0));
            if (!vs_p && vsync) vs_rise.push_back(int'(cyc - c0));
            if (!tk_p && frame_tick) tk.push_back(int'(cyc - c0));
            if (tk_p && frame_tick) tk_wide++;
            hs_p = hsync;
            vs_p = vsync;
            tk_p = frame_tick;
        end
    end

    function automatic int qget(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    // Pixel (x,y) of frame f is registered on edge c0 + 2 + 2*index.
    function automatic int unsigned pix_cyc(input int f, input int x, input int y);
        return c0 + 2 + 2 * (f * FR + y * HT + x);
    endfunction

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic        bl;
        logic [23:0] rgb;
    } pix_t;

    pix_t tbl[$];

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned c1;
        int          n;
        int          tks;

        // Frame 0: reset shadows (ball 240 off-raster, pillar 640 clipped, score 0).
        tbl.push_back('{0,   0,  0, 1'b1, C_BG});
        tbl.push_back('{0, 300,  0, 1'b1, C_BG});
        tbl.push_back('{0, 640,  0, 1'b0, C_BLK});
        tbl.push_back('{0, 213,  1, 1'b1, C_BG});
        tbl.push_back('{0, 639,  5, 1'b1, C_BG});
        tbl.push_back('{0,   0, 12, 1'b0, C_BLK});
        // Frame 1: ball_y=1, pillar 300/3 (gap rows 3..6), score 3.
        tbl.push_back('{1,   0,  0, 1'b1, C_SC});
        tbl.push_back('{1,  14,  0, 1'b1, C_BG});
        tbl.push_back('{1,  32,  0, 1'b1, C_SC});
        tbl.push_back('{1,  48,  0, 1'b1, C_BG});
        tbl.push_back('{1, 300,  0, 1'b1, C_PIL});
        tbl.push_back('{1, 212,  1, 1'b1, C_BG});
        tbl.push_back('{1, 213,  1, 1'b1, C_BALL});
        tbl.push_back('{1, 222,  1, 1'b1, C_BALL});
        tbl.push_back('{1, 223,  1, 1'b1, C_BG});
        tbl.push_back('{1, 299,  2, 1'b1, C_BG});
        tbl.push_back('{1, 300,  2, 1'b1, C_PIL});
        tbl.push_back('{1, 300,  3, 1'b1, C_BG});
        tbl.push_back('{1, 349,  6, 1'b1, C_BG});
        tbl.push_back('{1,  13,  7, 1'b1, C_SC});
        tbl.push_back('{1,  47,  7, 1'b1, C_BG});
        tbl.push_back('{1, 349,  7, 1'b1, C_PIL});
        tbl.push_back('{1, 350,  7, 1'b1, C_BG});
        tbl.push_back('{1,   0,  8, 1'b1, C_BG});
        tbl.push_back('{1, 213, 10, 1'b1, C_BALL});
        tbl.push_back('{1, 213, 11, 1'b1, C_BG});
        tbl.push_back('{1, 640, 11, 1'b0, C_BLK});
        // Frame 2: ball_y=2 (rows 2..11), pillar 200/0 (lower from row 4), score 200.
        tbl.push_back('{2,   0,  0, 1'b1, C_SC});
        tbl.push_back('{2, 199,  0, 1'b1, C_SC});
        tbl.push_back('{2, 200,  0, 1'b1, C_SC});
        tbl.push_back('{2, 624,  0, 1'b1, C_SC});
        tbl.push_back('{2, 637,  0, 1'b1, C_SC});
        tbl.push_back('{2, 638,  0, 1'b1, C_BG});
        tbl.push_back('{2, 639,  0, 1'b1, C_BG});
        tbl.push_back('{2, 213,  1, 1'b1, C_SC});
        tbl.push_back('{2, 213,  2, 1'b1, C_BALL});
        tbl.push_back('{2, 210,  5, 1'b1, C_PIL});
        tbl.push_back('{2, 213,  5, 1'b1, C_BALL});
        tbl.push_back('{2, 249,  5, 1'b1, C_PIL});
        tbl.push_back('{2, 250,  5, 1'b1, C_SC});
        tbl.push_back('{2, 199,  8, 1'b1, C_BG});
        tbl.push_back('{2, 200,  8, 1'b1, C_PIL});
        tbl.push_back('{2, 212, 11, 1'b1, C_PIL});
        tbl.push_back('{2, 213, 11, 1'b1, C_BALL});
        tbl.push_back('{2, 222, 11, 1'b1, C_BALL});
        tbl.push_back('{2, 223, 11, 1'b1, C_PIL});

        reset    = 1'b0;
        ball_y   = 10'd0;
        pillar_x = 10'd0;
        pillar_y = 10'd0;
        score    = 8'd0;
        repeat (5) @(negedge clk);
        check("reset hsync", 32'(hsync), 32'd1);
        check("reset vsync", 32'(vsync), 32'd1);
        check("reset blank_n", 32'(blank_n), 32'd0);
        check("reset rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("reset frame_tick", 32'(frame_tick), 32'd0);

        // State A is present from release but must only take effect after the first tick.
        ball_y   = 10'd1;
        pillar_x = 10'd300;
        pillar_y = 10'd3;
        score    = 8'd3;
        c0       = cyc;
        reset    = 1'b1;
        mon_en   = 1'b1;

        fork
            begin
                // Mid-frame change (frame 1, row 5) to state B.
                wait_cyc(pix_cyc(1, 0, 5));
                ball_y   = 10'd2;
                pillar_x = 10'd200;
                pillar_y = 10'd0;
                score    = 8'd200;
            end
            begin
                foreach (tbl[i]) begin
                    if (cyc > pix_cyc(tbl[i].f, tbl[i].x, tbl[i].y)) begin
                        checks++;
                        errors++;
                        $display("FAIL order f%0d (%0d,%0d): sample time already passed",
                                 tbl[i].f, tbl[i].x, tbl[i].y);
                    end else begin
                        wait_cyc(pix_cyc(tbl[i].f, tbl[i].x, tbl[i].y));
                        check($sformatf("blank_n f%0d (%0d,%0d)", tbl[i].f, tbl[i].x, tbl[i].y),
                              32'(blank_n), 32'(tbl[i].bl));
                        check($sformatf("rgb f%0d (%0d,%0d)", tbl[i].f, tbl[i].x, tbl[i].y),
                              32'({vga_r, vga_g, vga_b}), 32'(tbl[i].rgb));
                    end
                end
            end
        join
        mon_en = 1'b0;

        check("first hsync fall", 32'(qget(hs_fall, 0)), 32'd1314);
        check("hsync low width", 32'(qget(hs_rise, 0) - qget(hs_fall, 0)), 32'd192);
        check("hsync period", 32'(qget(hs_fall, 1) - qget(hs_fall, 0)), 32'd1600);
        check("first vsync fall", 32'(qget(vs_fall, 0)), 32'd20802);
        check("vsync low width", 32'(qget(vs_rise, 0) - qget(vs_fall, 0)), 32'd3200);
        check("vsync period", 32'(qget(vs_fall, 1) - qget(vs_fall, 0)), 32'(VT * 1600));
        check("first frame_tick", 32'(qget(tk, 0)), 32'd19201);
        check("frame_tick spacing", 32'(qget(tk, 1) - qget(tk, 0)), 32'(VT * 1600));
        check("frame_tick count", 32'(tk.size()), 32'd2);
        check("frame_tick width", 32'(tk_wide), 32'd0);

        // Reset in the middle of the visible area of frame 2.
        check("mid blank_n before reset", 32'(blank_n), 32'd1);
        reset = 1'b0;
        #1;
        check("mid reset blank_n", 32'(blank_n), 32'd0);
        check("mid reset rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("mid reset hsync", 32'(hsync), 32'd1);
        @(negedge clk);
        tks   = tick_total;
        c1    = cyc;
        reset = 1'b1;
        wait_cyc(c1 + 2);
        check("restart (0,0) blank_n", 32'(blank_n), 32'd1);
        check("restart (0,0) rgb", 32'({vga_r, vga_g, vga_b}), 32'(C_BG));
        n = 0;
        while (hsync && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("restart hsync fall", 32'(cyc - c1), 32'd1314);
        wait_cyc(c1 + 2 + 2 * (5 * HT + 210));
        check("restart shadows (210,5)", 32'({vga_r, vga_g, vga_b}), 32'(C_BG));
        check("no tick after restart", 32'(tick_total - tks), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
